// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, defaults and queue entry type for the fetch sequencer
package fetch_pkg;
   localparam int XLEN = 32;
   localparam int INST_BYTES = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction queue of {pc, inst} with flush and same-cycle head
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] occ,
   output fetch_entry_t     head
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_entry;
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - credit-limited sequential instruction fetch with redirect and stale-response drop
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int QUEUE_DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] OUT_PC,
   output logic [XLEN-1:0] OUT_INST,
   output logic            INST_RDEN,
   output logic [XLEN-1:0] INST_RADDR,
   input  logic            MEM_WAIT,
   input  logic            INST_RVALID,
   input  logic [XLEN-1:0] INST_RDATA
);
   logic rden_q, rden_d;
   logic [XLEN-1:0] raddr_q, raddr_d;
   logic [XLEN-1:0] next_pc_q, next_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic accept, push, pop, credit_ok;
   logic [CNT_W:0] credit_sum;
   logic [XLEN-1:0] issue_pc;
   logic [CNT_W-1:0] occ;
   fetch_entry_t push_entry, head;

   fetch_queue #(.DEPTH(QUEUE_DEPTH), .CNT_W(CNT_W)) u_queue (
      .CLK(CLK), .RST(RST), .push(push), .push_entry(push_entry), .pop(pop),
      .flush(REDIRECT), .occ(occ), .head(head)
   );

   always_comb begin
      accept     = rden_q & ~MEM_WAIT;
      push       = INST_RVALID & ~REDIRECT & (drop_q == '0);
      OUT_VALID  = (occ != '0) & ~REDIRECT;
      pop        = OUT_VALID & OUT_READY;
      push_entry = '{pc: resp_pc_q, inst: INST_RDATA};
      // Stale reads in flight still hold credit until they return.
      credit_sum = {1'b0, occ} + {1'b0, outstanding_q} + (CNT_W+1)'(accept);
      credit_ok  = credit_sum < (CNT_W+1)'(QUEUE_DEPTH);

      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(INST_RVALID);
      drop_d        = drop_q;
      resp_pc_d     = resp_pc_q;
      if (REDIRECT) begin
         drop_d    = outstanding_d;
         resp_pc_d = REDIRECT_PC;
      end else if (INST_RVALID) begin
         if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
         else              resp_pc_d = resp_pc_q + XLEN'(INST_BYTES);
      end

      rden_d    = rden_q;
      raddr_d   = raddr_q;
      next_pc_d = next_pc_q;
      issue_pc  = REDIRECT ? REDIRECT_PC : next_pc_q;
      if (rden_q && MEM_WAIT) begin
         if (REDIRECT) begin
            raddr_d   = REDIRECT_PC;
            next_pc_d = REDIRECT_PC + XLEN'(INST_BYTES);
         end
      end else begin
         rden_d = credit_ok;
         if (credit_ok) begin
            raddr_d   = issue_pc;
            next_pc_d = issue_pc + XLEN'(INST_BYTES);
         end else begin
            next_pc_d = issue_pc;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rden_q        <= 1'b0;
         raddr_q       <= RESET_PC;
         next_pc_q     <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         rden_q        <= rden_d;
         raddr_q       <= raddr_d;
         next_pc_q     <= next_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   assign INST_RDEN  = rden_q;
   assign INST_RADDR = raddr_q;
   assign OUT_PC     = head.pc;
   assign OUT_INST   = head.inst;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl with an in-order MMU model
module tb_fetch_ctrl;
   localparam int QD = 4;

   logic CLK = 1'b0;
   logic RST, REDIRECT, OUT_READY, MEM_WAIT, INST_RVALID;
   logic [31:0] REDIRECT_PC, INST_RDATA;
   logic OUT_VALID, INST_RDEN;
   logic [31:0] OUT_PC, OUT_INST, INST_RADDR;

   fetch_ctrl #(.RESET_PC(32'h0), .QUEUE_DEPTH(QD), .CNT_W(3)) dut (
      .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC), .OUT_INST(OUT_INST),
      .INST_RDEN(INST_RDEN), .INST_RADDR(INST_RADDR), .MEM_WAIT(MEM_WAIT),
      .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic [31:0] addr; int due; } mmu_req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

   mmu_req_t mmu_q[$];
   exp_t exp_q[$];
   int n_checks = 0, n_fail = 0, n_pops = 0, n_acc = 0, cyc = 0;
   int lat_min = 1, lat_max = 1;
   logic [31:0] gen_pc = 0, exp_addr = 0;
   bit seq_chk = 0, gap_chk = 0, seen_valid = 0;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every accepted output word must be the next word of the current stream.
   always @(negedge CLK) begin
      if (!RST) begin
         if (REDIRECT) check("valid_during_redirect", 32'(OUT_VALID), 32'h0);
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: got pc %h with nothing expected", OUT_PC);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_pc", OUT_PC, e.pc);
               check("out_inst", OUT_INST, e.inst);
               n_pops++;
            end
         end
      end
   end

   task automatic cycle();
      mmu_req_t r;
      @(negedge CLK);
      if (!RST) begin
         if (gap_chk) begin
            if (seen_valid) check("no_gap", 32'(OUT_VALID), 32'h1);
            if (OUT_VALID) seen_valid = 1;
         end
         check("inflight_bound", 32'(mmu_q.size() <= QD), 32'h1);
         if (INST_RDEN && !MEM_WAIT) begin
            if (seq_chk) begin
               check("raddr_seq", INST_RADDR, exp_addr);
               exp_addr += 4;
            end
            r.addr = INST_RADDR;
            r.due  = cyc + int'($urandom_range(lat_min, lat_max));
            mmu_q.push_back(r);
            n_acc++;
         end
      end
      @(posedge CLK);
      #1;
      cyc++;
      if (mmu_q.size() != 0 && mmu_q[0].due <= cyc) begin
         r = mmu_q.pop_front();
         INST_RVALID = 1'b1;
         INST_RDATA  = mem_word(r.addr);
      end else begin
         INST_RVALID = 1'b0;
         INST_RDATA  = $urandom;
      end
      while (exp_q.size() < 8) begin
         exp_t e;
         e.pc   = gen_pc;
         e.inst = mem_word(gen_pc);
         exp_q.push_back(e);
         gen_pc += 4;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; REDIRECT = 1'b0; OUT_READY = 1'b0; MEM_WAIT = 1'b0;
      mmu_q.delete();
      exp_q.delete();
      gen_pc = 32'h0;
      cycle();
      cycle();
      check("rst_rden", 32'(INST_RDEN), 32'h0);
      check("rst_raddr", INST_RADDR, 32'h0);
      check("rst_out_valid", 32'(OUT_VALID), 32'h0);
      RST = 1'b0;
   endtask

   task automatic redirect_to(logic [31:0] pc);
      REDIRECT = 1'b1;
      REDIRECT_PC = pc;
      exp_q.delete();
      gen_pc = pc;
      cycle();
      REDIRECT = 1'b0;
   endtask

   initial begin
      RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; OUT_READY = 1'b0;
      MEM_WAIT = 1'b0; INST_RVALID = 1'b0; INST_RDATA = 32'h0;
      @(posedge CLK);
      #1;

      // Streaming: one-cycle MMU, no back-pressure, sequential addresses and no gaps.
      do_reset();
      OUT_READY = 1'b1;
      seq_chk = 1; gap_chk = 1; seen_valid = 0; exp_addr = 32'h0;
      repeat (25) cycle();
      seq_chk = 0; gap_chk = 0;
      check("stream_started", 32'(seen_valid), 32'h1);

      // Back-pressure: exactly QD accepts, then one more per pop.
      do_reset();
      n_acc = 0;
      repeat (12) cycle();
      check("credit_accepts", n_acc, QD);
      check("credit_rden_low", 32'(INST_RDEN), 32'h0);
      check("credit_full_valid", 32'(OUT_VALID), 32'h1);
      OUT_READY = 1'b1;
      cycle();
      OUT_READY = 1'b0;
      repeat (6) cycle();
      check("credit_after_pop", n_acc, QD + 1);
      check("credit_rden_low2", 32'(INST_RDEN), 32'h0);

      // Held request under MEM_WAIT, then redirected while still waiting.
      do_reset();
      MEM_WAIT = 1'b1;
      OUT_READY = 1'b1;
      cycle();
      repeat (5) begin
         cycle();
         check("wait_rden", 32'(INST_RDEN), 32'h1);
         check("wait_raddr", INST_RADDR, 32'h0);
      end
      redirect_to(32'h0000_0200);
      check("wait_redirect_raddr", INST_RADDR, 32'h0000_0200);
      check("wait_redirect_rden", 32'(INST_RDEN), 32'h1);
      MEM_WAIT = 1'b0;
      repeat (10) cycle();

      // Address wrap on redirect near the top of memory.
      lat_max = 3;
      redirect_to(32'hFFFF_FFF8);
      repeat (12) cycle();

      // Random traffic: wait states, back-pressure, latencies and redirects.
      lat_max = 4;
      repeat (3000) begin
         MEM_WAIT  = ($urandom_range(0, 9) < 3);
         OUT_READY = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 3) == 0)
               redirect_to(32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2));
            else
               redirect_to($urandom & 32'hFFFF_FFFC);
         end else begin
            cycle();
         end
      end

      MEM_WAIT = 1'b0;
      OUT_READY = 1'b1;
      repeat (30) cycle();
      check("enough_pops", 32'(n_pops > 300), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the core front end and the instruction read port of mmu_axi. It replaces the free-running address counter in the top level.
- Generates sequential fetch addresses and respects MEM_WAIT. Credit-limits in-flight reads against a local instruction queue.
- Buffers returned words with their PC. On a redirect, flushes the queue and discards stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QUEUE_DEPTH, 4, instruction queue entries; must be a power of 2, ≥2.
- CNT_W, 3, width of the occupancy, outstanding and drop counters; must satisfy 2^CNT_W > QUEUE_DEPTH.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- REDIRECT  in  1  branch/exception redirect pulse
- REDIRECT_PC  in  32  new fetch PC, word aligned
- OUT_VALID  out  1  queue head valid to decode
- OUT_READY  in  1  decode accepts head
- OUT_PC  out  32  PC of head instruction
- OUT_INST  out  32  head instruction word
- INST_RDEN  out  1  read request to MMU (registered)
- INST_RADDR  out  32  request address (registered)
- MEM_WAIT  in  1  MMU busy; request not accepted while high
- INST_RVALID  in  1  read data valid pulse; responses return in request order
- INST_RDATA  in  32  read data

Interface: reset RST, synchronous, active-high; clock CLK.

Behaviour:
Reset values:
- INST_RDEN=0, INST_RADDR=RESET_PC, OUT_VALID=0.
- Queue empty; occupancy, outstanding and drop counters = 0; resp_pc=RESET_PC.

Request handshake:
- A request is accepted at a clock edge where INST_RDEN=1 and MEM_WAIT=0. At that edge outstanding increments.
- While MEM_WAIT=1, INST_RDEN and INST_RADDR hold, except on redirect (below).

Issue and credit:
- Credit check: occupancy + outstanding + (1 if a request is accepted this edge) < QUEUE_DEPTH.
- After an accepted request, or while INST_RDEN=0:
  - If the credit check passes, the next edge drives INST_RDEN=1 with the next address (previous INST_RADDR+4).
  - Otherwise INST_RDEN=0.
- Addresses wrap modulo 2^32 (32'hFFFF_FFFC → 0).
- The first request after reset appears at the cycle after RST deasserts, at RESET_PC.
- Stale in-flight reads still consume credit. This is conservative and intended.

Response handling:
- On INST_RVALID with drop_cnt>0: data discarded, drop_cnt−1, outstanding−1.
- On INST_RVALID with drop_cnt=0: push {resp_pc, INST_RDATA}, resp_pc+=4, outstanding−1.
- Push on a full queue cannot occur; the bench asserts this.

Output handshake:
- OUT_VALID = (occupancy≠0) & ~REDIRECT. OUT_PC and OUT_INST come from the queue head.
- Pop when OUT_VALID & OUT_READY.
- Simultaneous push and pop leaves occupancy unchanged.

Redirect (cycle where REDIRECT=1), at the edge:
- Queue flushed (occupancy=0); any INST_RVALID that cycle is discarded.
- drop_cnt ← outstanding after this edge's accept/return accounting.
- resp_pc ← REDIRECT_PC.
- Pending request:
  - If not accepted this edge (INST_RDEN=1, MEM_WAIT=1): INST_RADDR ← REDIRECT_PC, INST_RDEN stays 1.
  - If accepted or idle: the next request is REDIRECT_PC, subject to credit.
- A redirect while drop_cnt>0 is legal; drop_cnt is recomputed per the rule above.

Other rules:
- Reset mid-operation: immediate return to reset state. In-flight MMU responses after reset are not protected; the MMU is reset by the same RST.
- Counters never exceed QUEUE_DEPTH; drop_cnt ≤ outstanding always.

Decomposition:
- Package fetch_pkg: XLEN=32, INST_BYTES=4, default RESET_PC.
- One sub-module, fetch_queue: synchronous FIFO of {pc,inst}, QUEUE_DEPTH entries, with push, pop, flush, occupancy, and head outputs available in the same cycle.
- The credit, drop and address logic stay in fetch_ctrl.

Test Plan:
1. Reset release, MMU returns data 1 cycle after each accept, MEM_WAIT=0, OUT_READY=1 → INST_RADDR sequence 0,4,8,…; OUT_PC/OUT_INST pairs in order; no gaps after the first word.
2. OUT_READY=0, QUEUE_DEPTH=4 → exactly 4 requests accepted, then INST_RDEN=0. Set OUT_READY=1 → one new request issued per pop.
3. MEM_WAIT=1 for 5 cycles with INST_RDEN=1, INST_RADDR=0x10 → address held at 0x10. REDIRECT to 0x200 during wait → INST_RADDR=0x200; the first OUT_PC is 0x200.
4. Two reads outstanding (0x20, 0x24), REDIRECT to 0x100 → both responses discarded (drop_cnt 2→0); the next OUT_PC is 0x100 with the data returned for 0x100.
5. REDIRECT coincident with INST_RVALID and an accepted request → the returning word is dropped, drop_cnt = new outstanding, OUT_VALID=0 that cycle, queue empty the next cycle.
6. REDIRECT_PC=32'hFFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000; the PCs wrap correctly on the output.
